// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - single-issue ALU execute stage with multi-cycle sll and output hold
//
// Purpose:
//    Accepts one ALU operation at a time using a valid/ready handshake. Most codes
//    complete on the accept edge. sll shifts its operand one bit per cycle. The
//    result is then held until the downstream stage takes it.
//
// Ports:
//    clk        in   sole clock, rising edge
//    reset      in   asynchronous, active-high reset
//    InValid    in   upstream operation valid
//    InReady    out  stage can accept an operation (IDLE only)
//    AluCtrl    in   4-bit operation code
//    OperandA   in   first operand (rs or link address)
//    OperandB   in   second operand (rt or sign-extended immediate)
//    Shamt      in   shift amount for sll
//    OutValid   out  Result/flags valid (HOLD only)
//    OutReady   in   downstream accepts result
//    Result     out  registered ALU result
//    Zero       out  registered: Result is all zeros
//    Overflow   out  registered: signed overflow on add/sub codes
//    IllegalOp  out  registered: AluCtrl was not a defined code

module alu_exec_stage #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             InValid,
   output logic             InReady,
   input  logic [3:0]       AluCtrl,
   input  logic [WIDTH-1:0] OperandA,
   input  logic [WIDTH-1:0] OperandB,
   input  logic [4:0]       Shamt,
   output logic             OutValid,
   input  logic             OutReady,
   output logic [WIDTH-1:0] Result,
   output logic             Zero,
   output logic             Overflow,
   output logic             IllegalOp
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [4:0]       count;

   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic [WIDTH-1:0] shifted;
   logic             lt;

   logic [WIDTH-1:0] alu_res;
   logic             alu_ovf;
   logic             alu_ill;
   logic             is_shift;

   assign sum     = OperandA + OperandB;
   assign diff    = OperandA - OperandB;
   assign lt      = ($signed(OperandA) < $signed(OperandB));
   assign shifted = {Result[WIDTH-2:0], 1'b0};

   // Single-cycle result for the operation presented on the inputs. For sll
   // this is only the starting value; the shifting happens in SHIFT.
   always_comb begin
      alu_res  = '0;
      alu_ovf  = 1'b0;
      alu_ill  = 1'b0;
      is_shift = 1'b0;
      case (AluCtrl)
         4'b0010, 4'b0011, 4'b1000, 4'b1001: begin
            alu_res = sum;
            // Operands with the same sign give a sum with the other sign.
            alu_ovf = (OperandA[WIDTH-1] == OperandB[WIDTH-1]) &&
                      (sum[WIDTH-1] != OperandA[WIDTH-1]);
         end
         4'b1010: begin
            alu_res = diff;
            // Operands with different signs give a difference whose sign differs from A.
            alu_ovf = (OperandA[WIDTH-1] != OperandB[WIDTH-1]) &&
                      (diff[WIDTH-1] != OperandA[WIDTH-1]);
         end
         4'b0000, 4'b0001: alu_res = OperandA & OperandB;
         4'b1100:          alu_res = ~(OperandA | OperandB);
         4'b0111:          alu_res = {{(WIDTH-1){1'b0}}, lt};
         4'b1111, 4'b1011: alu_res = OperandA;
         4'b0100: begin
            is_shift = 1'b1;
            alu_res  = OperandB;
         end
         default:          alu_ill = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      InReady    = 1'b0;
      OutValid   = 1'b0;
      case (state)
         IDLE: begin
            InReady = 1'b1;
            if (InValid) begin
               state_next = (is_shift && (Shamt != 5'd0)) ? SHIFT : HOLD;
            end
         end
         SHIFT: begin
            // count == 1 means this edge takes the counter to zero.
            if (count == 5'd1) begin
               state_next = HOLD;
            end
         end
         HOLD: begin
            OutValid = 1'b1;
            if (OutReady) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         Result    <= '0;
         count     <= 5'd0;
         Zero      <= 1'b0;
         Overflow  <= 1'b0;
         IllegalOp <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (InValid) begin
                  Result    <= alu_res;
                  Zero      <= (alu_res == '0);
                  Overflow  <= alu_ovf;
                  IllegalOp <= alu_ill;
                  count     <= is_shift ? Shamt : 5'd0;
               end
            end
            SHIFT: begin
               Result <= shifted;
               count  <= count - 5'd1;
               // Zero must describe the final shifted value.
               if (count == 5'd1) begin
                  Zero <= (shifted == '0);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb/tb_alu_exec_stage.sv - randomized self-checking bench for alu_exec_stage

module tb_alu_exec_stage;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        InValid = 1'b0;
   logic        InReady;
   logic [3:0]  AluCtrl = 4'd0;
   logic [31:0] OperandA = 32'd0;
   logic [31:0] OperandB = 32'd0;
   logic [4:0]  Shamt = 5'd0;
   logic        OutValid;
   logic        OutReady = 1'b0;
   logic [31:0] Result;
   logic        Zero;
   logic        Overflow;
   logic        IllegalOp;

   int pass_cnt = 0;
   int total_cnt = 0;

   alu_exec_stage #(.WIDTH(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .InValid   (InValid),
      .InReady   (InReady),
      .AluCtrl   (AluCtrl),
      .OperandA  (OperandA),
      .OperandB  (OperandB),
      .Shamt     (Shamt),
      .OutValid  (OutValid),
      .OutReady  (OutReady),
      .Result    (Result),
      .Zero      (Zero),
      .Overflow  (Overflow),
      .IllegalOp (IllegalOp)
   );

   always #5 clk = ~clk;

   // Reference model: the operation table evaluated with wide integer arithmetic.
   task automatic model(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, output logic [31:0] r, output logic z,
                        output logic ov, output logic ill);
      longint wide;
      r = 32'd0; ov = 1'b0; ill = 1'b0;
      case (ctrl)
         4'd2, 4'd3, 4'd8, 4'd9: begin
            wide = longint'($signed(a)) + longint'($signed(b));
            r = wide[31:0];
            ov = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
         end
         4'd10: begin
            wide = longint'($signed(a)) - longint'($signed(b));
            r = wide[31:0];
            ov = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
         end
         4'd0, 4'd1: r = a & b;
         4'd12:      r = ~(a | b);
         4'd7:       r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
         4'd15, 4'd11: r = a;
         4'd4:       r = b << sh;
         default:    ill = 1'b1;
      endcase
      z = (r == 32'd0);
   endtask

   // One operation from the accept edge to the return to IDLE. Called in the
   // posedge+1 phase with the stage idle; hold = cycles of OutReady=0 in HOLD.
   task automatic run_op(input string name, input logic [3:0] ctrl, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh, input int hold);
      logic [31:0] er;
      logic        ez, eo, ei;
      int          lat, cyc;
      model(ctrl, a, b, sh, er, ez, eo, ei);
      lat = (ctrl == 4'd4) ? int'(sh) + 1 : 1;
      InValid = 1'b1; AluCtrl = ctrl; OperandA = a; OperandB = b; Shamt = sh;
      OutReady = (hold == 0);
      total_cnt++;
      if (InReady !== 1'b1) $display("FAIL %s in_ready_idle: got %b expected 1", name, InReady);
      else pass_cnt++;
      @(posedge clk); #1;
      cyc = 1;
      // Garbage on the inputs must be ignored once the op is taken.
      InValid = 1'($urandom_range(0, 1)); AluCtrl = 4'($urandom);
      OperandA = $urandom; OperandB = $urandom; Shamt = 5'($urandom);
      while (OutValid !== 1'b1 && cyc < 100) begin
         total_cnt++;
         if (InReady !== 1'b0) $display("FAIL %s in_ready_busy: got %b expected 0", name, InReady);
         else pass_cnt++;
         @(posedge clk); #1;
         cyc++;
         OperandA = $urandom; OperandB = $urandom;
      end
      total_cnt++;
      if (cyc !== lat) $display("FAIL %s latency: got %0d expected %0d", name, cyc, lat);
      else pass_cnt++;
      total_cnt++;
      if (Result !== er) $display("FAIL %s result: got %h expected %h", name, Result, er);
      else pass_cnt++;
      total_cnt++;
      if ({Zero, Overflow, IllegalOp} !== {ez, eo, ei})
         $display("FAIL %s flags zoi: got %b%b%b expected %b%b%b", name, Zero, Overflow, IllegalOp, ez, eo, ei);
      else pass_cnt++;
      for (int i = 0; i < hold; i++) begin
         InValid = 1'b1; OperandA = $urandom; OperandB = $urandom; AluCtrl = 4'($urandom);
         @(posedge clk); #1;
         total_cnt++;
         if (OutValid !== 1'b1 || InReady !== 1'b0 || Result !== er ||
             {Zero, Overflow, IllegalOp} !== {ez, eo, ei})
            $display("FAIL %s hold_%0d: got v=%b r=%b res=%h expected v=1 r=0 res=%h", name, i, OutValid, InReady, Result, er);
         else pass_cnt++;
      end
      OutReady = 1'b1;
      @(posedge clk); #1;
      InValid = 1'b0;
      total_cnt++;
      if (OutValid !== 1'b0 || InReady !== 1'b1)
         $display("FAIL %s release: got v=%b r=%b expected v=0 r=1", name, OutValid, InReady);
      else pass_cnt++;
   endtask

   task automatic test_reset;
      reset = 1'b1; InValid = 1'b1; AluCtrl = 4'd2; OperandA = 32'd5; OperandB = 32'd6;
      #1;
      total_cnt++;
      if (OutValid !== 1'b0 || InReady !== 1'b1 || Result !== 32'd0 ||
          {Zero, Overflow, IllegalOp} !== 3'b000)
         $display("FAIL reset_state: got v=%b r=%b res=%h zoi=%b%b%b expected v=0 r=1 res=0 zoi=000",
                  OutValid, InReady, Result, Zero, Overflow, IllegalOp);
      else pass_cnt++;
      repeat (2) @(posedge clk);
      #1;
      total_cnt++;
      if (OutValid !== 1'b0 || Result !== 32'd0)
         $display("FAIL reset_no_accept: got v=%b res=%h expected v=0 res=0", OutValid, Result);
      else pass_cnt++;
      InValid = 1'b0;
      reset = 1'b0;
   endtask

   task automatic test_add_overflow;
      run_op("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h1, 5'd0, 0);
      run_op("sub_ovf", 4'b1010, 32'h8000_0000, 32'h1, 5'd0, 0);
      run_op("add_wrap", 4'b1000, 32'hFFFF_FFFF, 32'h1, 5'd0, 0);
   endtask

   task automatic test_beq;
      run_op("beq_equal", 4'b1010, 32'h1234, 32'h1234, 5'd0, 0);
   endtask

   task automatic test_sll;
      run_op("sll_4", 4'b0100, 32'h0, 32'h3, 5'd4, 0);
      run_op("sll_0", 4'b0100, 32'h0, 32'h3, 5'd0, 0);
      run_op("sll_31", 4'b0100, 32'h0, 32'h3, 5'd31, 0);
      run_op("sll_out", 4'b0100, 32'h0, 32'hF000_0000, 5'd4, 1);
   endtask

   task automatic test_backpressure;
      run_op("slt_bp", 4'b0111, 32'hFFFF_FFFF, 32'h1, 5'd0, 3);
   endtask

   task automatic test_illegal;
      run_op("illegal_d", 4'b1101, 32'hDEAD_BEEF, 32'h1, 5'd0, 0);
      run_op("illegal_5", 4'b0101, 32'h0, 32'h0, 5'd7, 0);
   endtask

   task automatic test_reset_mid_shift;
      InValid = 1'b1; AluCtrl = 4'b0100; OperandA = 32'h0; OperandB = 32'h1; Shamt = 5'd31;
      OutReady = 1'b1;
      @(posedge clk); #1;
      InValid = 1'b0;
      repeat (2) @(posedge clk);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      total_cnt++;
      if (OutValid !== 1'b0 || Result !== 32'd0 || InReady !== 1'b1)
         $display("FAIL mid_shift_reset: got v=%b res=%h r=%b expected v=0 res=0 r=1", OutValid, Result, InReady);
      else pass_cnt++;
      #1 reset = 1'b0;
      run_op("after_reset", 4'b0010, 32'd100, 32'd23, 5'd0, 0);
   endtask

   task automatic test_random;
      logic [3:0]  c;
      logic [31:0] a, b;
      for (int i = 0; i < 40; i++) begin
         c = 4'($urandom_range(0, 15));
         a = $urandom;
         b = (i % 5 == 0) ? a : $urandom;
         run_op("random", c, a, b, 5'($urandom), int'($urandom_range(0, 2)));
      end
   endtask

   task automatic test_back_to_back;
      for (int i = 0; i < 4; i++) begin
         run_op("b2b", 4'b0000, $urandom, $urandom, 5'd0, 0);
      end
   endtask

   initial begin
      test_reset();
      @(posedge clk); #1;
      test_add_overflow();
      test_beq();
      test_sll();
      test_backpressure();
      test_illegal();
      test_reset_mid_shift();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/alu_exec_stage.md
ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32: datapath width of operands and result.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port InValid  input  1  upstream operation valid.
REQ-005 SHALL have port InReady  output  1  stage can accept an operation this cycle.
REQ-006 SHALL have port AluCtrl  input  4  4-bit ALU operation code from the ALU control unit.
REQ-007 SHALL have port OperandA  input  WIDTH  first operand (rs value, or link address for jal).
REQ-008 SHALL have port OperandB  input  WIDTH  second operand (rt value or sign-extended immediate).
REQ-009 SHALL have port Shamt  input  5  shift amount for sll.
REQ-010 SHALL have port OutValid  output  1  Result/flags valid.
REQ-011 SHALL have port OutReady  input  1  downstream accepts result.
REQ-012 SHALL have port Result  output  WIDTH  registered ALU result.
REQ-013 SHALL have ports Zero, Overflow, IllegalOp  output  1 each  registered flags.

Function
REQ-014 SHALL implement states IDLE, SHIFT, HOLD; InReady = 1 only in IDLE.
REQ-015 SHALL accept an operation on a rising edge where state = IDLE and InValid = 1; operands and AluCtrl are captured at that edge only.
REQ-016 SHALL decode AluCtrl: 0010/0011/1000/1001 = A+B; 1010 = A-B; 0000/0001 = A AND B; 1100 = NOR(A,B); 0111 = signed A<B ? 1 : 0; 1111/1011 = pass A; 0100 = sll B by Shamt.
REQ-017 SHALL, for non-shift codes, register Result and flags at the accept edge and enter HOLD (OutValid 1 cycle after accept).
REQ-018 SHALL compute add/sub modulo 2^WIDTH; Overflow = signed two's-complement overflow for add/sub codes, 0 otherwise.
REQ-019 SHALL set Zero = 1 when registered Result is all zeros, for every code.
REQ-020 SHALL, for sll with Shamt = 0, load Result = OperandB and enter HOLD directly.
REQ-021 SHALL, for sll with Shamt = N > 0, load Result = OperandB and counter = N, enter SHIFT, shift Result left by 1 (zero fill) and decrement counter each cycle, enter HOLD on the edge the counter reaches 0; OutValid rises N+1 cycles after accept.
REQ-022 SHALL treat codes 0101, 0110, 1101, 1110 as illegal: Result = 0, Zero = 1, Overflow = 0, IllegalOp = 1, latency as non-shift; IllegalOp = 0 for all legal codes.
REQ-023 SHALL hold OutValid = 1 and Result/flags stable in HOLD until OutReady = 1; on that edge return to IDLE with OutValid = 0.
REQ-024 SHALL ignore InValid and all operand inputs while in SHIFT or HOLD.
REQ-025 SHALL ignore OutReady outside HOLD.
REQ-026 SHALL keep OutValid = 0 in IDLE and SHIFT.

Reset
REQ-027 SHALL, on reset = 1, immediately force state = IDLE, Result = 0, counter = 0, OutValid = 0, Zero = 0, Overflow = 0, IllegalOp = 0, regardless of clk.
REQ-028 SHALL abandon any operation in SHIFT or HOLD on reset; no result is produced for it.
REQ-029 SHALL accept a new operation on the first rising edge after reset deasserts.

Verification
REQ-030 add: AluCtrl=0010, A=0x7FFFFFFF, B=1, OutReady=1 -> 1 cycle later OutValid=1, Result=0x80000000, Overflow=1, Zero=0; IDLE next cycle.
REQ-031 beq: AluCtrl=1010, A=B=0x1234 -> Result=0, Zero=1, Overflow=0 after 1 cycle.
REQ-032 sll: AluCtrl=0100, B=0x00000003, Shamt=4 -> InReady=0 for 5 cycles, OutValid rises 5 cycles after accept, Result=0x00000030; Shamt=0 -> Result=0x00000003 after 1 cycle.
REQ-033 backpressure: slt A=0xFFFFFFFF, B=1, OutReady=0 for 3 cycles with InValid=1 and changing operands -> Result=1 held stable, InReady=0, no new accept until edge with OutReady=1.
REQ-034 illegal: AluCtrl=1101 -> Result=0, Zero=1, IllegalOp=1 after 1 cycle.
REQ-035 reset mid-shift: sll Shamt=31, assert reset 3 cycles after accept -> OutValid=0, Result=0, InReady=1 immediately; next op after release completes normally.
